seven_segment_scanner: RTL

- Time-multiplexed scan controller for the seven-segment display on mprj_io[15:9]; sits between the firmware-facing register logic and the segment and digit-enable pins.
- Holds one 4-bit hex value per digit in double-buffered registers and decodes it to segments.
- Sequences digits with a blanking gap between them to prevent ghosting.
- Commits new values to the display only at frame boundaries, so the display never shows a partial update.

---
 rtl/seven_segment_scanner_if.sv | 49 ++++
 rtl/seven_segment_scanner.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/seven_segment_scanner_if.sv
`default_nettype none
// ============================================================================
// Module      : seven_segment_scanner_if
// Description : Bundle between the firmware-facing register logic (master)
//               and the seven-segment scan controller (slave).
//               wr_en/wr_addr/wr_data : shadow register write port
//               commit                : request shadow -> active at frame end
//               commit_pending        : a commit is waiting for frame end
//               segments              : decoded segments, bit0=a .. bit6=g
//               digit_en              : one-hot digit enable
//               frame_done            : one-cycle pulse at end of a scan
//               brightness            : PWM duty (only with
//                                       SEVEN_SEGMENT_SCANNER_BRIGHTNESS_EN)
// Revision    : 1.0 - initial release
// ============================================================================
interface seven_segment_scanner_if #(
    parameter int ADDR_W = 2
);
    localparam int NUM_DIGITS = 2 ** ADDR_W;

    logic                  wr_en;
    logic [ADDR_W-1:0]     wr_addr;
    logic [3:0]            wr_data;
    logic                  commit;
    logic                  commit_pending;
    logic [6:0]            segments;
    logic [NUM_DIGITS-1:0] digit_en;
    logic                  frame_done;
`ifdef SEVEN_SEGMENT_SCANNER_BRIGHTNESS_EN
    logic [3:0]            brightness;
`endif

    modport master (
`ifdef SEVEN_SEGMENT_SCANNER_BRIGHTNESS_EN
        output brightness,
`endif
        output wr_en, wr_addr, wr_data, commit,
        input  commit_pending, segments, digit_en, frame_done
    );

    modport slave (
`ifdef SEVEN_SEGMENT_SCANNER_BRIGHTNESS_EN
        input  brightness,
`endif
        input  wr_en, wr_addr, wr_data, commit,
        output commit_pending, segments, digit_en, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/seven_segment_scanner.sv
`default_nettype none
// ============================================================================
// Module      : seven_segment_scanner
// Description : Time-multiplexed seven-segment scan controller with
//               double-buffered digit registers, blanking gaps between
//               digits and frame-aligned commit of new values.
// Ports       : clock - system clock (rising edge)
//               reset - asynchronous, active-high reset
//               bus   - seven_segment_scanner_if.slave (write port, commit,
//                       segments, digit_en, frame_done, commit_pending)
// Options     : SEVEN_SEGMENT_SCANNER_BRIGHTNESS_EN adds a 4-bit PWM
//               brightness control on the segment outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module seven_segment_scanner #(
    parameter int ADDR_W       = 2,
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 8,
    parameter int CNT_W        = 16
) (
    input  wire logic               clock,
    input  wire logic               reset,
    seven_segment_scanner_if.slave  bus
);
    localparam int NUM_DIGITS = 2 ** ADDR_W;

    localparam logic [0:0] c_st_blank = 1'b0;
    localparam logic [0:0] c_st_show  = 1'b1;

    localparam logic [CNT_W-1:0]  c_blank_last = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0]  c_show_last  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [ADDR_W-1:0] c_last_idx   = {ADDR_W{1'b1}};

    logic [0:0]                       r_state;
    logic [CNT_W-1:0]                 r_cnt;
    logic [ADDR_W-1:0]                r_idx;
    logic [NUM_DIGITS-1:0][3:0]       r_shadow;
    logic [NUM_DIGITS-1:0][3:0]       r_active;
    logic                             r_pending;
    logic [6:0]                       r_segments;
    logic [NUM_DIGITS-1:0]            r_digit_en;
    logic                             r_frame_done;

    logic [0:0]                       w_state_nx;
    logic [CNT_W-1:0]                 w_cnt_nx;
    logic [ADDR_W-1:0]                w_idx_nx;
    logic                             w_frame_end;
    logic                             w_frame_done_nx;
    logic [6:0]                       w_seg_nx;
    logic [NUM_DIGITS-1:0]            w_den_nx;

`ifdef SEVEN_SEGMENT_SCANNER_BRIGHTNESS_EN
    logic [3:0]                       r_pwm;
    logic [3:0]                       w_pwm_nx;
    assign w_pwm_nx = r_pwm + 4'd1;
`endif

    function automatic logic [6:0] f_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
            4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
            4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
            4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Current cycle is the last lit cycle of the last digit.
    assign w_frame_end = (r_state == c_st_show) && (r_cnt == c_show_last) &&
                         (r_idx == c_last_idx);

    // Next-state logic. Outputs are registered from the next state so that
    // they line up with the state register cycle for cycle.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt + CNT_W'(1);
        w_idx_nx   = r_idx;
        if (r_state == c_st_blank) begin
            if (r_cnt == c_blank_last) begin
                w_state_nx = c_st_show;
                w_cnt_nx   = '0;
            end
        end else begin
            if (r_cnt == c_show_last) begin
                w_state_nx = c_st_blank;
                w_cnt_nx   = '0;
                // NUM_DIGITS is a power of two, so the increment wraps.
                w_idx_nx   = r_idx + ADDR_W'(1);
            end
        end
    end

    always_comb begin
        w_seg_nx        = '0;
        w_den_nx        = '0;
        w_frame_done_nx = (w_state_nx == c_st_show) && (w_cnt_nx == c_show_last) &&
                          (w_idx_nx == c_last_idx);
        if (w_state_nx == c_st_show) begin
            // The transfer edge always leads into BLANK, so r_active is
            // already settled whenever a digit is about to be lit.
            w_seg_nx = f_decode(r_active[w_idx_nx]);
            w_den_nx = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << w_idx_nx;
        end
`ifdef SEVEN_SEGMENT_SCANNER_BRIGHTNESS_EN
        if (w_pwm_nx >= bus.brightness) begin
            w_seg_nx = '0;
        end
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= c_st_blank;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_shadow     <= '0;
            r_active     <= '0;
            r_pending    <= 1'b0;
            r_segments   <= '0;
            r_digit_en   <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_cnt        <= w_cnt_nx;
            r_idx        <= w_idx_nx;
            r_segments   <= w_seg_nx;
            r_digit_en   <= w_den_nx;
            r_frame_done <= w_frame_done_nx;
            if (bus.wr_en) begin
                r_shadow[bus.wr_addr] <= bus.wr_data;
            end
            // Non-blocking copy: a write on the transfer cycle stays in shadow.
            if (w_frame_end) begin
                if (r_pending || bus.commit) begin
                    r_active <= r_shadow;
                end
                r_pending <= 1'b0;
            end else if (bus.commit) begin
                r_pending <= 1'b1;
            end
        end
    end

`ifdef SEVEN_SEGMENT_SCANNER_BRIGHTNESS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pwm <= '0;
        end else begin
            r_pwm <= w_pwm_nx;
        end
    end
`endif

    assign bus.segments       = r_segments;
    assign bus.digit_en       = r_digit_en;
    assign bus.frame_done     = r_frame_done;
    assign bus.commit_pending = r_pending;

endmodule
`default_nettype wire
